// File: rtl/cpu_ctrl_pkg.sv
// Shared run-control definitions for the 5-stage core: run states, the default drain depth,
// and the halt opcode decoded in ID.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } run_state_t;

  localparam int unsigned DRAIN_CYCLES_DEFAULT = 4;

  // ecall major opcode; ID raises halt_instr when it sees this
  localparam logic [6:0] HALT_OPCODE = 7'h73;

endpackage

// File: rtl/run_counter.sv
// Free-running DATA_W counter with increment enable and synchronous clear (clear wins).
module run_counter #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [DATA_W-1:0] cnt_o
);

  logic [DATA_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + DATA_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run-control sequencer: owns the global pipeline enable and drains in-flight instructions on halt.
// Optional cycle counter enabled by defining PIPELINE_RUN_CTRL_PERF_EN.
module pipeline_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              step,
  input  logic              stop,
  input  logic              clear,
  input  logic              halt_instr,
  input  logic              ext_busy,
  input  logic [DATA_W-1:0] max_instr,
  output logic              pipe_en,
  output logic              fetch_valid,
  output logic              flush_if,
  output logic              running,
  output logic              done,
  output logic [DATA_W-1:0] instr_cnt,
  output logic [DATA_W-1:0] cycle_cnt
);

  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);

  run_state_t     state_q, state_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           done_q;
  logic           cnt_clr;
  logic           instr_inc;
  logic           limit_hit;
  logic [DATA_W:0] next_cnt;

  // >= rather than == so an exhausted limit still stops a resume after one fetch
  assign next_cnt  = {1'b0, instr_cnt} + (DATA_W + 1)'(1);
  assign limit_hit = (max_instr != '0) && (next_cnt >= {1'b0, max_instr});

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !ext_busy)     state_d = RUN;
        else if (step && !ext_busy) state_d = STEP;
        else if (clear)             cnt_clr = 1'b1;
      end
      RUN: begin
        if (stop || halt_instr || limit_hit) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      STEP: begin
        state_d = DRAIN;
        drain_d = DRAIN_LOAD;
      end
      DRAIN: begin
        drain_d = drain_q - DCW'(1);
        if (drain_q == DCW'(1)) state_d = HALTED;
      end
      HALTED: begin
        if (start && !ext_busy)     state_d = RUN;
        else if (step && !ext_busy) state_d = STEP;
        else if (clear) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= (state_d == HALTED) && (state_q != HALTED);
    end
  end

  assign pipe_en     = (state_q == RUN) || (state_q == STEP) || (state_q == DRAIN);
  assign fetch_valid = (state_q == RUN) || (state_q == STEP);
  assign running     = fetch_valid;
  assign done        = done_q;
  assign flush_if    = (state_q == RUN) && halt_instr;
  assign instr_inc   = ((state_q == RUN) && !halt_instr) || (state_q == STEP);

  run_counter #(.DATA_W(DATA_W)) u_instr_cnt (
    .clk_i  (clk),
    .rst_ni (arst_n),
    .clr_i  (cnt_clr),
    .inc_i  (instr_inc),
    .cnt_o  (instr_cnt)
  );

`ifdef PIPELINE_RUN_CTRL_PERF_EN
  run_counter #(.DATA_W(DATA_W)) u_cycle_cnt (
    .clk_i  (clk),
    .rst_ni (arst_n),
    .clr_i  (cnt_clr),
    .inc_i  (pipe_en),
    .cnt_o  (cycle_cnt)
  );
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed self-checking bench for pipeline_run_ctrl.
module tb_pipeline_run_ctrl;

  logic        clk = 1'b0;
  logic        arst_n, start, step, stop, clear, halt_instr, ext_busy;
  logic [63:0] max_instr;
  logic        pipe_en, fetch_valid, flush_if, running, done;
  logic [63:0] instr_cnt, cycle_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n_pe, n_done, n_drain;

`ifdef PIPELINE_RUN_CTRL_PERF_EN
  localparam logic [63:0] EXP_CYC9 = 64'd9;
`else
  localparam logic [63:0] EXP_CYC9 = 64'd0;
`endif

  pipeline_run_ctrl #(.DATA_W(64), .DRAIN_CYCLES(4)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (start),
    .step        (step),
    .stop        (stop),
    .clear       (clear),
    .halt_instr  (halt_instr),
    .ext_busy    (ext_busy),
    .max_instr   (max_instr),
    .pipe_en     (pipe_en),
    .fetch_valid (fetch_valid),
    .flush_if    (flush_if),
    .running     (running),
    .done        (done),
    .instr_cnt   (instr_cnt),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe the current cycle and the next `cycles-1`, counting pipe_en and done cycles.
  task automatic observe(input int unsigned cycles);
    n_pe   = 0;
    n_done = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      if (pipe_en) n_pe++;
      if (done)    n_done++;
      tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0; clear = 1'b0;
    halt_instr = 1'b0; ext_busy = 1'b0; max_instr = 64'd0;
    tick(); tick();
    arst_n = 1'b1;
    check_eq("rst_pipe_en", 64'(pipe_en), 64'd0);
    check_eq("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    check_eq("rst_running", 64'(running), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_instr_cnt", instr_cnt, 64'd0);
    check_eq("rst_cycle_cnt", cycle_cnt, 64'd0);

    // max_instr=5: five RUN cycles plus four DRAIN cycles
    max_instr = 64'd5;
    pulse_start();
    check_eq("run_pipe_en_first", 64'(pipe_en), 64'd1);
    observe(30);
    check_eq("lim_pe_cycles", 64'(n_pe), 64'd9);
    check_eq("lim_done_pulses", 64'(n_done), 64'd1);
    check_eq("lim_instr_cnt", instr_cnt, 64'd5);
    check_eq("lim_cycle_cnt", cycle_cnt, EXP_CYC9);
    check_eq("lim_halted_pe", 64'(pipe_en), 64'd0);

    // resume with limit already reached: one fetch then drain
    pulse_start();
    observe(30);
    check_eq("resume_pe_cycles", 64'(n_pe), 64'd5);
    check_eq("resume_instr_cnt", instr_cnt, 64'd6);

    // clear in HALTED, then single steps
    max_instr = 64'd0;
    pulse_clear();
    check_eq("clr_instr_cnt", instr_cnt, 64'd0);
    check_eq("clr_cycle_cnt", cycle_cnt, 64'd0);
    pulse_step();
    observe(30);
    check_eq("step1_pe_cycles", 64'(n_pe), 64'd5);
    check_eq("step1_done", 64'(n_done), 64'd1);
    check_eq("step1_instr_cnt", instr_cnt, 64'd1);
    pulse_step();
    observe(30);
    check_eq("step2_pe_cycles", 64'(n_pe), 64'd5);
    check_eq("step2_instr_cnt", instr_cnt, 64'd2);

    // halt_instr in the 3rd RUN cycle
    pulse_clear();
    pulse_start();
    tick(); tick();
    halt_instr = 1'b1;
    #1;
    check_eq("halt_flush_if", 64'(flush_if), 64'd1);
    check_eq("halt_fetch_valid", 64'(fetch_valid), 64'd1);
    tick();
    halt_instr = 1'b0;
    n_drain = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pipe_en && !fetch_valid && !done) n_drain++;
      tick();
    end
    check_eq("halt_drain_cycles", 64'(n_drain), 64'd4);
    check_eq("halt_done", 64'(done), 64'd1);
    check_eq("halt_instr_cnt", instr_cnt, 64'd2);
    check_eq("halt_pipe_en", 64'(pipe_en), 64'd0);

    // stop and halt_instr together: one drain, one done
    pulse_clear();
    pulse_start();
    tick();
    stop = 1'b1; halt_instr = 1'b1;
    tick();
    stop = 1'b0; halt_instr = 1'b0;
    observe(30);
    check_eq("dual_pe_cycles", 64'(n_pe), 64'd4);
    check_eq("dual_done", 64'(n_done), 64'd1);
    check_eq("dual_instr_cnt", instr_cnt, 64'd1);

    // ext_busy blocks start
    pulse_clear();
    ext_busy = 1'b1;
    pulse_start();
    check_eq("busy_pipe_en", 64'(pipe_en), 64'd0);
    check_eq("busy_running", 64'(running), 64'd0);
    ext_busy = 1'b0;
    tick();
    pulse_start();
    check_eq("unbusy_running", 64'(running), 64'd1);

    // clear in RUN ignored
    pulse_clear();
    check_eq("run_clear_running", 64'(running), 64'd1);
    check_eq("run_clear_cnt", instr_cnt, 64'd1);
    tick();
    check_eq("run_clear_cnt2", instr_cnt, 64'd2);

    // reset in 2nd DRAIN cycle
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("stop_drain_fv", 64'(fetch_valid), 64'd0);
    tick();
    arst_n = 1'b0; tick(); arst_n = 1'b1;
    check_eq("mid_rst_pipe_en", 64'(pipe_en), 64'd0);
    check_eq("mid_rst_running", 64'(running), 64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    check_eq("mid_rst_instr_cnt", instr_cnt, 64'd0);
    check_eq("mid_rst_cycle_cnt", cycle_cnt, 64'd0);
    tick();
    check_eq("mid_rst_stay_idle", 64'(pipe_en), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
